// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline boundary: two-entry skid buffer with a registered zero flag per entry.
// in_ready comes straight from a flop, so MEM backpressure never forms a combinational path back into EX.
module ex_mem_skid #(
  parameter int DW = 8,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_result,
  input  logic [DW-1:0] in_store,
  input  logic [RW-1:0] in_dest,
  input  logic          in_mem_read,
  input  logic          in_mem_write,
  input  logic          in_reg_write,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [DW-1:0] out_store,
  output logic [RW-1:0] out_dest,
  output logic          out_mem_read,
  output logic          out_mem_write,
  output logic          out_reg_write,
  output logic          out_zero
);

  typedef struct packed {
    logic [DW-1:0] result;
    logic [DW-1:0] store;
    logic [RW-1:0] dest;
    logic          mem_read;
    logic          mem_write;
    logic          reg_write;
    logic          zero;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  logic   accept;
  logic   pop;

  // The zero flag is evaluated once at capture and then travels with its entry.
  always_comb begin
    in_entry           = '0;
    in_entry.result    = in_result;
    in_entry.store     = in_store;
    in_entry.dest      = in_dest;
    in_entry.mem_read  = in_mem_read;
    in_entry.mem_write = in_mem_write;
    in_entry.reg_write = in_reg_write;
    in_entry.zero      = ~|in_result;
  end

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d          = EMPTY;
      main_d.mem_read  = 1'b0;
      main_d.mem_write = 1'b0;
      main_d.reg_write = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = in_entry;
          end else if (accept) begin
            skid_d  = in_entry;
            state_d = FULL;
          end else if (pop) begin
            // Head drained: an invalid head must not carry live control bits.
            main_d.mem_read  = 1'b0;
            main_d.mem_write = 1'b0;
            main_d.reg_write = 1'b0;
            state_d          = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_result    = main_q.result;
  assign out_store     = main_q.store;
  assign out_dest      = main_q.dest;
  assign out_mem_read  = main_q.mem_read;
  assign out_mem_write = main_q.mem_write;
  assign out_reg_write = main_q.reg_write;
  assign out_zero      = main_q.zero;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed and random stimulus for ex_mem_skid, checked against a queue-based FIFO scoreboard.
module tb_ex_mem_skid;

  typedef struct packed {
    logic [7:0] result;
    logic [7:0] store;
    logic [2:0] dest;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_result, in_store, out_result, out_store;
  logic [2:0] in_dest, out_dest;
  logic       in_mem_read, in_mem_write, in_reg_write;
  logic       out_mem_read, out_mem_write, out_reg_write, out_zero;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  ex_mem_skid #(.DW(8), .RW(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_store(in_store), .in_dest(in_dest),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_reg_write(in_reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store(out_store), .out_dest(out_dest),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_reg_write(out_reg_write),
    .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, ".out_result"}, {24'd0, out_result}, 32'd0);
    chk({tag, ".out_store"}, {24'd0, out_store}, 32'd0);
    chk({tag, ".out_dest"}, {29'd0, out_dest}, 32'd0);
    chk({tag, ".ctrl"}, {29'd0, out_mem_read, out_mem_write, out_reg_write}, 32'd0);
    chk({tag, ".out_zero"}, {31'd0, out_zero}, 32'd0);
  endtask

  // Outputs are all registered, so they are compared #1 after the edge against the scoreboard head.
  task automatic check_outputs();
    chk("out_valid", {31'd0, out_valid}, {31'd0, (sb.size() > 0)});
    chk("in_ready", {31'd0, in_ready}, {31'd0, (sb.size() < 2)});
    if (sb.size() > 0) begin
      chk("out_result", {24'd0, out_result}, {24'd0, sb[0].result});
      chk("out_store", {24'd0, out_store}, {24'd0, sb[0].store});
      chk("out_dest", {29'd0, out_dest}, {29'd0, sb[0].dest});
      chk("out_ctrl", {29'd0, out_mem_read, out_mem_write, out_reg_write},
          {29'd0, sb[0].mem_read, sb[0].mem_write, sb[0].reg_write});
      chk("out_zero", {31'd0, out_zero}, {31'd0, (sb[0].result == 8'h00)});
    end else begin
      chk("idle_ctrl", {29'd0, out_mem_read, out_mem_write, out_reg_write}, 32'd0);
    end
  endtask

  task automatic step(input logic iv, input logic [7:0] res, input logic [7:0] st,
                      input logic [2:0] dst, input logic mr, input logic mw, input logic rw,
                      input logic ordy, input logic fl, input logic rst);
    exp_t e;
    logic acc_m, pop_m;
    check_outputs();
    in_valid     = iv;
    in_result    = res;
    in_store     = st;
    in_dest      = dst;
    in_mem_read  = mr;
    in_mem_write = mw;
    in_reg_write = rw;
    out_ready    = ordy;
    flush        = fl;
    reset        = rst;
    e = '{result: res, store: st, dest: dst, mem_read: mr, mem_write: mw, reg_write: rw};
    if (rst || fl) begin
      sb.delete();
    end else begin
      acc_m = iv && (sb.size() < 2);
      pop_m = ordy && (sb.size() > 0);
      if (pop_m) void'(sb.pop_front());
      if (acc_m) sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_result = '0; in_store = '0; in_dest = '0;
    in_mem_read = 1'b0; in_mem_write = 1'b0; in_reg_write = 1'b0;

    // Reset held for two cycles, then idle.
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all_zero("reset");
    idle(1'b0);
    check_all_zero("reset_idle");

    // Streaming with MEM always ready; includes the zero / SLT boundary values.
    step(1'b1, 8'h05, 8'h11, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h00, 8'h22, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h01, 8'h33, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Backpressure: two entries fill the skid, the third push must be dropped.
    step(1'b1, 8'hA1, 8'h01, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 8'h02, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 8'h03, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Back-to-back accept and pop in ONE: no bubbles.
    for (int i = 0; i < 8; i++)
      step(1'b1, 8'h10 + 8'(i), 8'(i), 3'(i), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Flush from FULL together with a new input: nothing survives.
    step(1'b1, 8'h31, 8'h00, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h32, 8'h00, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h55, 8'h55, 3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Reset and flush together from FULL: reset wins, everything returns to zero.
    step(1'b1, 8'h41, 8'h41, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h42, 8'h42, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_outputs();
    in_valid = 1'b1; in_result = 8'h66; flush = 1'b1; reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check_all_zero("reset_flush");

    // Random traffic with a flush in the middle.
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 255)),
           8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'(i == 40), 1'b0);
    repeat (3) idle(1'b1);
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
- Registered EX→MEM boundary of the 8-bit MIPS datapath.
- Captures the 8-bit ALU result (including set-less-than output), store data, destination register and memory/writeback control. It presents them to the MEM stage over a valid/ready handshake.
- A 2-entry skid buffer lets the execute stage keep issuing for one cycle after MEM deasserts ready, with no combinational ready path.
- Also generates a registered zero flag for branch resolution and supports pipeline flush.

Parameters:
- DW, 8, ALU result / store data width
- RW, 3, destination register index width (8-entry register file)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  discard all buffered entries (synchronous)
- in_valid  input  1  EX presents a valid result
- in_ready  output  1  buffer can accept this cycle; registered
- in_result  input  DW  ALU result (sum/logic/SLT)
- in_store  input  DW  rt data for store
- in_dest  input  RW  destination register index
- in_mem_read  input  1  load instruction
- in_mem_write  input  1  store instruction
- in_reg_write  input  1  writes register file
- out_valid  output  1  head entry valid to MEM
- out_ready  input  1  MEM accepts head entry
- out_result  output  DW  head ALU result
- out_store  output  DW  head store data
- out_dest  output  RW  head destination
- out_mem_read  output  1  head control
- out_mem_write  output  1  head control
- out_reg_write  output  1  head control
- out_zero  output  1  1 when out_result == 0; registered with the entry

Behaviour:
- Reset: clk and reset are one clock with a synchronous, active-high reset. On reset, all valids are 0, all out_* data/control and out_zero are 0, in_ready=1, and the state is EMPTY.
- Storage: main register (drives out_*) and skid register. The zero flag is computed at capture from in_result and stored with each entry.
- Acceptance: accept = in_valid & in_ready. Pop = out_valid & out_ready.
- States and transitions:
  - EMPTY: accept → main, go to ONE.
  - ONE:
    - accept & pop → main reloads from input, stay ONE.
    - accept & !pop → skid captures, go to FULL.
    - pop & !accept → go to EMPTY.
  - FULL: in_ready=0.
    - pop → main ← skid, go to ONE.
    - no pop → hold.
- in_ready = (state != FULL), driven from a register only.
- Latency: accepted entry appears on out_* the next cycle in EMPTY, or the same cycle main reloads in ONE. Order is strictly FIFO.
- out_* hold stable while out_valid=1 and out_ready=0.
- Input sampled when in_ready=0 is ignored; no entry is lost or duplicated.
- flush:
  - Flush has priority over accept and pop. Next state is EMPTY and in_ready=1.
  - Data registers need not clear, but out_valid=0 and out_mem_write=0, out_reg_write=0, out_mem_read=0 are forced.
- reset has priority over flush.
- reset or flush mid-transfer (FULL) drops both entries.
- Width: result passes through unmodified. out_zero = ~|result over all DW bits. SLT results 0x01/0x00 give out_zero 0/1.
- Control bits for an invalid head are 0.

Test Plan:
- Reset then idle: reset=1 for 2 cycles → out_valid=0, in_ready=1, all outputs 0, out_zero=0.
- Streaming: out_ready=1, inject results 0x05, 0x00, 0x01 on consecutive cycles → out_result 0x05, 0x00, 0x01 one cycle later each. out_zero is 0, 1, 0. in_ready stays 1.
- Backpressure/skid:
  - Setup: out_ready=0, push 0xA1 (dest 3, reg_write) then 0xB2 (dest 5, mem_write).
  - Cycle 2: in_ready=0; a third push 0xC3 is ignored.
  - Release out_ready: outputs 0xA1 then 0xB2, then in_ready=1. 0xC3 is never output.
- Simultaneous accept+pop in ONE: out_ready=1, continuous in_valid for 8 cycles, values 0x10..0x17 → 8 outputs in order, no bubbles.
- Flush: with state FULL, assert flush together with in_valid (0x55) → next cycle out_valid=0, in_ready=1, mem/reg control 0. 0x55 is not captured.
- Reset priority: reset and flush together in FULL, with in_valid → EMPTY and all outputs 0 next cycle.
